ed25519_addmodp_arb: RTL and testbench

ED25519_ADDMODP_ARB -- requirements
Module: ed25519_addmodp_arb

---
 rtl/ed25519_addmodp_arb_if.sv | 62 ++++++
 rtl/ed25519_addmodp_arb.sv | 172 +++++++++++++++++
 tb/tb_ed25519_addmodp_arb.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ed25519_addmodp_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ed25519_addmodp_arb_if
// Brief    : Bundle of request, shared-adder and result signals for the
//            ed25519 add-mod-p arbiter. The slave modport is the arbiter
//            view; the master modport is the requester/adder/consumer view.
// Revision : 1.0 - initial release
// ============================================================================
interface ed25519_addmodp_arb_if #(
    parameter int W  = 255,
    parameter int N  = 4,
    parameter int TW = 8,
    parameter int D  = 8
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int MW  = 1 + IDW + TW;
    localparam int CW  = $clog2(D + 1);

    // Requesters
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N*TW-1:0] req_tag;

    // Shared add-mod-p pipeline
    logic [W-1:0]    add_in0;
    logic [W-1:0]    add_in1;
    logic [MW-1:0]   add_m_i;
    logic [MW-1:0]   add_m_o;
    logic [W-1:0]    add_out0;

    // Result stream and status
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_data;
    logic [IDW-1:0]  res_id;
    logic [TW-1:0]   res_tag;
    logic [CW-1:0]   credits;
    logic            err;

    modport slave (
        input  req_valid, req_a, req_b, req_tag,
        input  add_m_o, add_out0,
        input  res_ready,
        output req_ready,
        output add_in0, add_in1, add_m_i,
        output res_valid, res_data, res_id, res_tag,
        output credits, err
    );

    modport master (
        output req_valid, req_a, req_b, req_tag,
        output add_m_o, add_out0,
        output res_ready,
        input  req_ready,
        input  add_in0, add_in1, add_m_i,
        input  res_valid, res_data, res_id, res_tag,
        input  credits, err
    );
endinterface
`default_nettype wire

// File: rtl/ed25519_addmodp_arb.sv
`default_nettype none
// ============================================================================
// Module   : ed25519_addmodp_arb
// Brief    : Round-robin arbiter in front of a shared fixed-latency add-mod-p
//            pipeline, with a credit-controlled first-word-fall-through
//            result FIFO that returns {result, id, tag} in issue order.
// Revision : 1.0 - initial release
// ============================================================================
module ed25519_addmodp_arb #(
    parameter int W  = 255,
    parameter int N  = 4,
    parameter int TW = 8,
    parameter int L  = 2,
    parameter int D  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ed25519_addmodp_arb_if.slave  bus
);
    localparam int IDW        = (N > 1) ? $clog2(N) : 1;
    localparam int MW         = 1 + IDW + TW;
    localparam int CW         = $clog2(D + 1);
    localparam int PW         = (D > 1) ? $clog2(D) : 1;
    localparam int EW         = W + IDW + TW;
    // An op occupies the operand register plus L adder stages while in flight.
    localparam int PIPE_SLOTS = L + 1;

    logic [IDW-1:0] ptr_q;
    logic [CW-1:0]  credits_q, credits_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_q, wr_q;
    logic           err_q;
    logic [W-1:0]   a_q, b_q;
    logic [MW-1:0]  m_q;
    logic [EW-1:0]  mem_q [D];

    int             start_idx;
    int             sel_idx;
    logic [2*N-1:0] dbl_valid;
    logic [N-1:0]   rot_valid;
    logic           found;
    logic           can_issue;
    logic [N-1:0]   grant;
    logic [W-1:0]   sel_a, sel_b;
    logic [TW-1:0]  sel_tag;

    logic           pop;
    logic           push;
    logic           err_set;
    logic           m_valid;
    logic           full;
    int             in_flight;
    logic [EW-1:0]  head;

    // Round-robin pick starting after the last issued id, plus operand mux
    always_comb begin
        start_idx = (int'(ptr_q) + 1) % N;
        dbl_valid = {bus.req_valid, bus.req_valid};
        rot_valid = N'(dbl_valid >> start_idx);
        found     = 1'b0;
        sel_idx   = 0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot_valid[j]) begin
                found   = 1'b1;
                sel_idx = (start_idx + j) % N;
            end
        end
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_idx == i) begin
                sel_a   = bus.req_a[i*W +: W];
                sel_b   = bus.req_b[i*W +: W];
                sel_tag = bus.req_tag[i*TW +: TW];
            end
        end
        can_issue = found && (credits_q != '0) && !rst;
        grant     = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = can_issue && (sel_idx == i);
        end
    end

    assign bus.req_ready = grant;

    // Result acceptance: a returning op must have been accounted as in flight
    assign m_valid   = bus.add_m_o[MW-1];
    assign full      = (count_q == CW'(D));
    assign pop       = (count_q != '0) && bus.res_ready;
    assign in_flight = D - int'(credits_q) - int'(count_q);
    assign push      = m_valid && (in_flight > 0) && (in_flight <= PIPE_SLOTS)
                       && (!full || pop);
    assign err_set   = m_valid && !push;

    // Credit and occupancy next-state; issue and pop in one cycle cancel out
    always_comb begin
        credits_d = credits_q;
        if (can_issue && !pop && (credits_q != '0)) begin
            credits_d = credits_q - CW'(1);
        end else if (pop && !can_issue && (credits_q != CW'(D))) begin
            credits_d = credits_q + CW'(1);
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Arbitration pointer, credits, FIFO pointers and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= IDW'(N - 1);
            credits_q <= CW'(D);
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            if (can_issue) begin
                ptr_q <= IDW'(sel_idx);
            end
            credits_q <= credits_d;
            count_q   <= count_d;
            if (push) begin
                wr_q <= (wr_q == PW'(D - 1)) ? '0 : wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= (rd_q == PW'(D - 1)) ? '0 : rd_q + PW'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Operand/metadata register feeding the shared adder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            m_q <= '0;
        end else if (can_issue) begin
            a_q <= sel_a;
            b_q <= sel_b;
            m_q <= {1'b1, IDW'(sel_idx), sel_tag};
        end else begin
            m_q[MW-1] <= 1'b0;
        end
    end

    // FIFO storage; unread slots never reach the outputs, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {bus.add_out0, bus.add_m_o[TW +: IDW], bus.add_m_o[TW-1:0]};
        end
    end

    assign head          = mem_q[rd_q];
    assign bus.add_in0   = a_q;
    assign bus.add_in1   = b_q;
    assign bus.add_m_i   = m_q;
    assign bus.res_valid = (count_q != '0);
    assign bus.res_data  = bus.res_valid ? head[EW-1 -: W]   : '0;
    assign bus.res_id    = bus.res_valid ? head[TW +: IDW]   : '0;
    assign bus.res_tag   = bus.res_valid ? head[TW-1:0]      : '0;
    assign bus.credits   = credits_q;
    assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_ed25519_addmodp_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ed25519_addmodp_arb
// Brief    : Directed self-checking bench for ed25519_addmodp_arb with a
//            behavioural L-stage add-mod-p pipeline sharing the reset.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ed25519_addmodp_arb;
    localparam int W   = 255;
    localparam int N   = 4;
    localparam int TW  = 8;
    localparam int L   = 2;
    localparam int D   = 8;
    localparam int IDW = 2;
    localparam int MW  = 1 + IDW + TW;
    localparam logic [W-1:0] P = {W{1'b1}} - W'(18);

    typedef struct {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
        logic [TW-1:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic inject = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    ed25519_addmodp_arb_if #(.W(W), .N(N), .TW(TW), .D(D)) bus();

    ed25519_addmodp_arb #(.W(W), .N(N), .TW(TW), .L(L), .D(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] addmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    // Behavioural shared adder: L register stages, same async reset
    logic [MW-1:0] pm [L];
    logic [W-1:0]  pd [L];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                pm[i] <= '0;
                pd[i] <= '0;
            end
        end else begin
            pm[0] <= bus.add_m_i;
            pd[0] <= addmod(bus.add_in0, bus.add_in1);
            for (int i = 1; i < L; i++) begin
                pm[i] <= pm[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign bus.add_m_o  = inject ? {1'b1, 2'd3, 8'hEE} : pm[L-1];
    assign bus.add_out0 = inject ? W'(77) : pd[L-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] t);
        bus.req_a[i*W +: W]    = a;
        bus.req_b[i*W +: W]    = b;
        bus.req_tag[i*TW +: TW] = t;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        inject = 1'b0;
        q.delete();
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        bus.req_valid = '1;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        n_checks++; if (bus.credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits: got %0d expected 8", bus.credits); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        n_checks++; if (bus.add_m_i !== '0) begin n_fail++; $display("FAIL reset_add_m_i: got %h expected 0", bus.add_m_i); end
        n_checks++; if (bus.add_in0 !== '0 || bus.add_in1 !== '0) begin n_fail++; $display("FAIL reset_add_in: got %h/%h expected 0/0", bus.add_in0, bus.add_in1); end
        n_checks++; if (bus.res_data !== '0 || bus.res_id !== '0 || bus.res_tag !== '0) begin n_fail++; $display("FAIL reset_res_fields: got %h/%0d/%h expected zeros", bus.res_data, bus.res_id, bus.res_tag); end
        apply_reset();
    endtask

    task automatic test_single_op();
        bus.res_ready = 1'b0;
        set_req(2, P - W'(1), W'(2), 8'h5A);
        bus.req_valid = 4'b0100;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        n_checks++; if (bus.add_m_i !== {1'b1, 2'd2, 8'h5A}) begin n_fail++; $display("FAIL single_add_m_i: got %h expected %h", bus.add_m_i, {1'b1, 2'd2, 8'h5A}); end
        n_checks++; if (bus.add_in0 !== P - W'(1) || bus.add_in1 !== W'(2)) begin n_fail++; $display("FAIL single_add_in: got %h/%h expected P-1/2", bus.add_in0, bus.add_in1); end
        n_checks++; if (bus.credits !== 4'd7) begin n_fail++; $display("FAIL single_credits_issue: got %0d expected 7", bus.credits); end
        step();
        n_checks++; if (bus.add_m_i[MW-1] !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_t2: got add_valid %b res_valid %b expected 0 0", bus.add_m_i[MW-1], bus.res_valid); end
        step();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", bus.res_valid); end
        step();
        n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got res_valid %b expected 1", bus.res_valid); end
        n_checks++; if (bus.res_data !== W'(1) || bus.res_id !== 2'd2 || bus.res_tag !== 8'h5A) begin n_fail++; $display("FAIL single_result: got %h/%0d/%h expected 1/2/5a", bus.res_data, bus.res_id, bus.res_tag); end
        step();
        step();
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== W'(1) || bus.res_tag !== 8'h5A) begin n_fail++; $display("FAIL single_hold: got %b/%h/%h expected 1/1/5a", bus.res_valid, bus.res_data, bus.res_tag); end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        n_checks++; if (bus.res_valid !== 1'b0 || bus.credits !== 4'd8) begin n_fail++; $display("FAIL single_pop: got valid %b credits %0d expected 0 8", bus.res_valid, bus.credits); end
    endtask

    task automatic test_fairness();
        int got;
        exp_t e;
        apply_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, W'(1000 + i), W'(16 * i), TW'(8'h10 + i));
        bus.req_valid = '1;
        #1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            int x;
            x = c % N;
            n_checks++; if (bus.req_ready !== 4'(1 << x)) begin n_fail++; $display("FAIL fair_grant%0d: got %b expected %b", c, bus.req_ready, 4'(1 << x)); end
            e.d = W'(1000 + 17 * x); e.id = IDW'(x); e.tag = TW'(8'h10 + x);
            q.push_back(e);
            if (bus.res_valid) begin
                e = q.pop_front();
                got++;
                n_checks++; if (bus.res_data !== e.d || bus.res_id !== e.id || bus.res_tag !== e.tag) begin n_fail++; $display("FAIL fair_result: got %0d/%0d/%h expected %0d/%0d/%h", bus.res_data, bus.res_id, bus.res_tag, e.d, e.id, e.tag); end
            end
            step();
        end
        bus.req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            if (bus.res_valid && q.size() > 0) begin
                e = q.pop_front();
                got++;
                n_checks++; if (bus.res_data !== e.d || bus.res_id !== e.id || bus.res_tag !== e.tag) begin n_fail++; $display("FAIL fair_result: got %0d/%0d/%h expected %0d/%0d/%h", bus.res_data, bus.res_id, bus.res_tag, e.d, e.id, e.tag); end
            end
            step();
        end
        n_checks++; if (got != 8 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL fair_count: got %0d results (valid %b) expected 8 (0)", got, bus.res_valid); end
    endtask

    task automatic test_back_to_back();
        int n;
        int m;
        exp_t e;
        apply_reset();
        n = 0;
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            set_req(0, W'(200 + n), W'(1), TW'(n));
            #1;
            if (bus.req_ready[0]) begin
                e.d = W'(201 + n); e.id = '0; e.tag = TW'(n);
                q.push_back(e);
                n++;
            end
            step();
        end
        n_checks++; if (n != 8) begin n_fail++; $display("FAIL bp_issue_count: got %0d expected 8", n); end
        n_checks++; if (bus.credits !== 4'd0 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stalled: got credits %0d ready %b expected 0 0000", bus.credits, bus.req_ready); end
        e = q.pop_front();
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== e.d || bus.res_tag !== e.tag) begin n_fail++; $display("FAIL bp_head: got %b/%0d/%h expected 1/%0d/%h", bus.res_valid, bus.res_data, bus.res_tag, e.d, e.tag); end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        m = 0;
        for (int c = 0; c < 10; c++) begin
            set_req(0, W'(200 + n), W'(1), TW'(n));
            #1;
            if (bus.req_ready[0]) begin
                e.d = W'(201 + n); e.id = '0; e.tag = TW'(n);
                q.push_back(e);
                n++;
                m++;
            end
            step();
        end
        n_checks++; if (m != 1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL bp_one_more: got %0d issues err %b expected 1 0", m, bus.err); end
    endtask

    task automatic test_push_pop_full();
        int n;
        exp_t e;
        n = 9;
        n_checks++; if (bus.credits !== 4'd0 || bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL full_start: got credits %0d valid %b expected 0 1", bus.credits, bus.res_valid); end
        bus.res_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            set_req(0, W'(200 + n), W'(1), TW'(n));
            #1;
            if (c >= 1) begin
                n_checks++; if (bus.credits !== 4'd1) begin n_fail++; $display("FAIL full_credits%0d: got %0d expected 1", c, bus.credits); end
            end
            if (bus.req_ready[0]) begin
                e.d = W'(201 + n); e.id = '0; e.tag = TW'(n);
                q.push_back(e);
                n++;
            end
            if (bus.res_valid && q.size() > 0) begin
                e = q.pop_front();
                n_checks++; if (bus.res_data !== e.d || bus.res_tag !== e.tag) begin n_fail++; $display("FAIL full_order: got %0d/%h expected %0d/%h", bus.res_data, bus.res_tag, e.d, e.tag); end
            end
            step();
        end
        bus.req_valid = '0;
        for (int c = 0; c < 20; c++) begin
            if (bus.res_valid && q.size() > 0) begin
                e = q.pop_front();
                n_checks++; if (bus.res_data !== e.d || bus.res_tag !== e.tag) begin n_fail++; $display("FAIL full_order: got %0d/%h expected %0d/%h", bus.res_data, bus.res_tag, e.d, e.tag); end
            end
            step();
        end
        n_checks++; if (q.size() != 0 || bus.credits !== 4'd8 || bus.err !== 1'b0) begin n_fail++; $display("FAIL full_drain: got left %0d credits %0d err %b expected 0 8 0", q.size(), bus.credits, bus.err); end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int seen;
        apply_reset();
        set_req(0, W'(5), W'(6), 8'h01);
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) step();
        n_checks++; if (bus.credits !== 4'd3 || bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got credits %0d valid %b expected 3 1", bus.credits, bus.res_valid); end
        rst = 1'b1;
        bus.req_valid = '1;
        #1;
        n_checks++; if (bus.res_valid !== 1'b0 || bus.credits !== 4'd8 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_async: got valid %b credits %0d ready %b expected 0 8 0000", bus.res_valid, bus.credits, bus.req_ready); end
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant: got %b expected 0001", bus.req_ready); end
        bus.req_valid = '0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.res_valid !== 1'b0 || bus.err !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d cycles with stale result/err expected 0", seen); end
    endtask

    task automatic test_err_inject();
        inject = 1'b1;
        step();
        inject = 1'b0;
        n_checks++; if (bus.err !== 1'b1 || bus.res_valid !== 1'b0 || bus.credits !== 4'd8) begin n_fail++; $display("FAIL err_set: got err %b valid %b credits %0d expected 1 0 8", bus.err, bus.res_valid, bus.credits); end
        step(); step(); step();
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
        apply_reset();
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", bus.err); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_single_op();
        test_fairness();
        test_back_to_back();
        test_push_pop_full();
        test_reset_midop();
        test_err_inject();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected end within 200000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
